pipeline_alu_param: RTL and testbench

Parametrised four-stage register/ALU/memory pipeline:
- Stage 1 reads two operands from a register bank.
- Stage 2 executes one of twelve ALU operations.
- Stage 3 writes the result back to the bank and presents it on `Zout`.
- Stage 4 stores the result into a data memory.

Compared with the earlier fixed-width, two-phase-clock pipeline, it runs on one clock and adds valid/hold flow control, operand forwarding, a defined illegal-op path and a registered memory read port.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/pipe_alu.sv | 35 +++
 rtl/pipeline_alu_param.sv | 109 ++++++++++
 tb/tb_pipeline_alu_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the register/ALU/memory pipeline: function codes and stage payloads.
// Stage payload fields are sized for the widest supported configuration; the top narrows them.
package pipeline_pkg;

  localparam int DW_MAX = 64;
  localparam int RW_MAX = 8;
  localparam int AW_MAX = 16;

  typedef enum logic [3:0] {
    FN_ADD, FN_SUB, FN_MUL, FN_PASS_A, FN_PASS_B, FN_AND,
    FN_OR, FN_XOR, FN_NOT_A, FN_NOT_B, FN_SHR, FN_SHL
  } func_e;

  localparam logic [3:0] FN_LAST = 4'd11;

  typedef struct packed {
    logic [DW_MAX-1:0] a;
    logic [DW_MAX-1:0] b;
    logic [RW_MAX-1:0] rd;
    logic [3:0]        func;
    logic [AW_MAX-1:0] addr;
  } s1_t;

  typedef struct packed {
    logic [DW_MAX-1:0] z;
    logic [RW_MAX-1:0] rd;
    logic [AW_MAX-1:0] addr;
  } s2_t;

  typedef struct packed {
    logic [AW_MAX-1:0] addr;
  } s3_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU for the execute stage; also drives the S1 forwarding path.
module pipe_alu
  import pipeline_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] z,
  output logic          legal
);

  assign legal = (func <= FN_LAST);

  always_comb begin
    z = '0;
    case (func)
      FN_ADD:    z = a + b;
      FN_SUB:    z = a - b;
      FN_MUL:    z = a * b;
      FN_PASS_A: z = a;
      FN_PASS_B: z = b;
      FN_AND:    z = a & b;
      FN_OR:     z = a | b;
      FN_XOR:    z = a ^ b;
      FN_NOT_A:  z = ~a;
      FN_NOT_B:  z = ~b;
      FN_SHR:    z = a >> 1;
      FN_SHL:    z = a << 1;
      default:   z = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_alu_param.sv
// Four-stage pipeline: S1 operand read with forwarding, S2 execute, S3 writeback/Zout,
// S4 data-memory store, plus an independent registered memory read port.
module pipeline_alu_param
  import pipeline_pkg::*;
#(
  parameter  int DW   = 16,
  parameter  int NREG = 16,
  parameter  int AW   = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          hold,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] Zout,
  output logic          out_valid,
  output logic          ill_op,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int STAGES = 2;

  logic [STAGES:0]         vld_pipe;   // [0]=S1, [1]=S2, [2]=S3
  s1_t                     s1_q;
  s2_t                     s2_q;
  s3_t                     s3_q;
  logic [NREG-1:0][DW-1:0] reg_bank;
  logic [DW-1:0]           mem [2**AW];

  logic [DW-1:0]           s1_a, s1_b, s2_z, alu_z;
  logic [RW-1:0]           s1_rd, s2_rd;
  logic                    alu_legal, ill_q, unused_ok;
  logic [1:0][RW-1:0]      src;
  logic [1:0][DW-1:0]      opnd;

  assign s1_a      = s1_q.a[DW-1:0];
  assign s1_b      = s1_q.b[DW-1:0];
  assign s1_rd     = s1_q.rd[RW-1:0];
  assign s2_z      = s2_q.z[DW-1:0];
  assign s2_rd     = s2_q.rd[RW-1:0];
  assign unused_ok = ^{s1_q, s2_q, s3_q};

  assign in_ready  = ~hold;
  assign out_valid = vld_pipe[2];
  assign ill_op    = ill_q & ~hold;

  pipe_alu #(.DW(DW)) u_alu (
    .func  (s1_q.func),
    .a     (s1_a),
    .b     (s1_b),
    .z     (alu_z),
    .legal (alu_legal)
  );

  // Youngest producer wins; an illegal op in S1 never forwards and never reaches S2 valid.
  assign src = {rs2, rs1};
  always_comb begin
    opnd = '0;
    for (int i = 0; i < 2; i++) begin
      if (vld_pipe[0] && alu_legal && s1_rd == src[i]) opnd[i] = alu_z;
      else if (vld_pipe[1] && s2_rd == src[i])         opnd[i] = s2_z;
      else                                             opnd[i] = reg_bank[src[i]];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      reg_bank <= '0;
      Zout     <= '0;
      ill_q    <= 1'b0;
    end else if (hold) begin
      ill_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], vld_pipe[0] & alu_legal, in_valid};
      ill_q    <= vld_pipe[0] & ~alu_legal;
      s1_q     <= '{a: DW_MAX'(opnd[0]), b: DW_MAX'(opnd[1]), rd: RW_MAX'(rd),
                    func: func, addr: AW_MAX'(addr)};
      s2_q     <= '{z: DW_MAX'(alu_z), rd: s1_q.rd, addr: s1_q.addr};
      if (vld_pipe[1]) begin
        reg_bank[s2_rd] <= s2_z;
        Zout            <= s2_z;
        s3_q.addr       <= s2_q.addr;
      end
    end
  end

  // Memory contents are deliberately not reset; S3 valid is, so nothing stores during reset.
  always_ff @(posedge CLK) begin
    if (!hold && vld_pipe[2]) mem[s3_q.addr[AW-1:0]] <= Zout;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_pipeline_alu_param.sv
// Directed bench for pipeline_alu_param: hand-computed Zout/valid/memory expectations per scenario.
module tb_pipeline_alu_param;

  localparam int DW = 16, NREG = 16, AW = 8, RW = 4;

  typedef struct { int f; int s1; int s2; int d; int a; int z; } vec_t;

  logic          CLK = 1'b0, RST_N = 1'b0, in_valid = 1'b0, hold = 1'b0, rd_en = 1'b0;
  logic [RW-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [3:0]    func = '0;
  logic [AW-1:0] addr = '0, rd_addr = '0;
  logic          in_ready, out_valid, ill_op;
  logic [DW-1:0] Zout, rd_data;
  int            errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  pipeline_alu_param #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .Zout(Zout), .out_valid(out_valid), .ill_op(ill_op),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    func     = v.f[3:0];
    rs1      = v.s1[RW-1:0];
    rs2      = v.s2[RW-1:0];
    rd       = v.d[RW-1:0];
    addr     = v.a[AW-1:0];
  endtask

  task automatic test_reset;
    RST_N = 1'b0; #2;
    checks++; if (Zout !== 16'h0) begin errors++; $display("FAIL reset_zout: got %h want 0000", Zout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (ill_op !== 1'b0) begin errors++; $display("FAIL reset_ill_op: got %b want 0", ill_op); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick; tick;
    RST_N = 1'b1;
    tick;
  endtask

  task automatic test_init;
    drive('{0, 0, 0, 1, 'hE0, 0});
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL init_k0_valid: got %b want 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL init_k1_valid: got %b want 0", out_valid); end
    tick;
    checks++;
    if (out_valid !== 1'b1 || Zout !== 16'h0) begin
      errors++; $display("FAIL init_k2: got v=%b z=%h want v=1 z=0000", out_valid, Zout);
    end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL init_k3_valid: got %b want 0", out_valid); end
  endtask

  // Builds r1=5, r2=3 from zeros using back-to-back dependent ops.
  task automatic test_build;
    vec_t v[8];
    v = '{'{8, 0, 0, 1, 'hE0, 'hFFFF}, '{1, 0, 1, 2, 'hE0, 1}, '{11, 2, 0, 3, 'hE0, 2},
          '{11, 3, 0, 4, 'hE0, 4}, '{0, 4, 2, 5, 'hE0, 5}, '{0, 3, 2, 6, 'h40, 3},
          '{3, 5, 0, 1, 'h30, 5}, '{3, 6, 0, 2, 'h10, 3}};
    for (int t = 0; t < 10; t++) begin
      if (t < 8) drive(v[t]); else in_valid = 1'b0;
      tick;
      if (t >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || Zout !== v[t-2].z[DW-1:0]) begin
          errors++; $display("FAIL build[%0d]: got v=%b z=%h want v=1 z=%h", t-2, out_valid, Zout, v[t-2].z[DW-1:0]);
        end
      end
    end
    tick;
  endtask

  task automatic test_forward;
    vec_t v[3];
    v = '{'{0, 1, 2, 3, 'hE0, 8}, '{2, 3, 3, 4, 'hE0, 64}, '{1, 4, 3, 5, 'hE0, 56}};
    for (int t = 0; t < 5; t++) begin
      if (t < 3) drive(v[t]); else in_valid = 1'b0;
      tick;
      if (t >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || Zout !== v[t-2].z[DW-1:0]) begin
          errors++; $display("FAIL forward[%0d]: got v=%b z=%h want v=1 z=%h", t-2, out_valid, Zout, v[t-2].z[DW-1:0]);
        end
      end
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || Zout !== 16'd56) begin
      errors++; $display("FAIL forward_idle: got v=%b z=%h want v=0 z=0038", out_valid, Zout);
    end
  endtask

  task automatic test_store_read;
    vec_t v[8];
    v = '{'{11, 4, 0, 9, 'hE0, 'h80}, '{10, 4, 0, 10, 'hE0, 'h20}, '{6, 9, 10, 11, 'hE0, 'hA0},
          '{6, 3, 2, 12, 'hE0, 'h0B}, '{5, 12, 1, 7, 'hE0, 'h01}, '{9, 0, 3, 8, 'hE0, 'hFFF7},
          '{4, 0, 12, 14, 'hE0, 'h0B}, '{7, 11, 12, 13, 'h10, 'hAB}};
    for (int t = 0; t < 10; t++) begin
      if (t < 8) drive(v[t]); else in_valid = 1'b0;
      tick;
      if (t >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || Zout !== v[t-2].z[DW-1:0]) begin
          errors++; $display("FAIL ops[%0d]: got v=%b z=%h want v=1 z=%h", t-2, out_valid, Zout, v[t-2].z[DW-1:0]);
        end
      end
    end
    rd_en = 1'b1; rd_addr = 8'h10;
    tick;
    checks++; if (rd_data !== 16'h0003) begin errors++; $display("FAIL read_same_edge: got %h want 0003", rd_data); end
    rd_en = 1'b0;
    tick;
    checks++; if (rd_data !== 16'h0003) begin errors++; $display("FAIL read_hold: got %h want 0003", rd_data); end
    rd_en = 1'b1;
    tick;
    checks++; if (rd_data !== 16'h00AB) begin errors++; $display("FAIL read_after_store: got %h want 00ab", rd_data); end
    rd_en = 1'b0;
  endtask

  task automatic test_illegal;
    drive('{13, 2, 3, 1, 'h30, 0});
    tick;
    checks++; if (ill_op !== 1'b0) begin errors++; $display("FAIL ill_k0: got %b want 0", ill_op); end
    drive('{0, 1, 0, 14, 'h50, 5});
    tick;
    checks++; if (ill_op !== 1'b1) begin errors++; $display("FAIL ill_k1_pulse: got %b want 1", ill_op); end
    in_valid = 1'b0;
    tick;
    checks++;
    if (ill_op !== 1'b0 || out_valid !== 1'b0 || Zout !== 16'h00AB) begin
      errors++; $display("FAIL ill_k2: got ill=%b v=%b z=%h want ill=0 v=0 z=00ab", ill_op, out_valid, Zout);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || Zout !== 16'h0005) begin
      errors++; $display("FAIL ill_dependent: got v=%b z=%h want v=1 z=0005", out_valid, Zout);
    end
    tick;
    rd_en = 1'b1; rd_addr = 8'h30;
    tick;
    checks++; if (rd_data !== 16'h0005) begin errors++; $display("FAIL ill_no_store: got %h want 0005", rd_data); end
    rd_en = 1'b0;
  endtask

  task automatic test_hold;
    drive('{0, 2, 2, 7, 'h40, 6});  tick;
    drive('{0, 7, 1, 8, 'h41, 11}); tick;
    drive('{0, 8, 7, 9, 'h42, 17}); tick;
    checks++;
    if (out_valid !== 1'b1 || Zout !== 16'd6) begin
      errors++; $display("FAIL hold_pre: got v=%b z=%h want v=1 z=0006", out_valid, Zout);
    end
    hold = 1'b1;
    drive('{0, 0, 0, 10, 'h43, 0});
    rd_en = 1'b1; rd_addr = 8'h40;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || Zout !== 16'd6 || rd_data !== 16'd3 || ill_op !== 1'b0) begin
        errors++; $display("FAIL hold_frozen[%0d]: got v=%b z=%h rd=%h ill=%b want v=1 z=0006 rd=0003 ill=0",
                           i, out_valid, Zout, rd_data, ill_op);
      end
    end
    hold = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b1 || Zout !== 16'd11) begin errors++; $display("FAIL hold_rel1: got v=%b z=%h want v=1 z=000b", out_valid, Zout); end
    tick;
    checks++; if (out_valid !== 1'b1 || Zout !== 16'd17) begin errors++; $display("FAIL hold_rel2: got v=%b z=%h want v=1 z=0011", out_valid, Zout); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_rel3: got v=%b want v=0", out_valid); end
    rd_en = 1'b1; rd_addr = 8'h40;
    tick;
    checks++;
    if (rd_data !== 16'd6 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_mem40: got rd=%h v=%b want rd=0006 v=0", rd_data, out_valid);
    end
    rd_addr = 8'h42;
    tick;
    checks++; if (rd_data !== 16'd17) begin errors++; $display("FAIL hold_mem42: got %h want 0011", rd_data); end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    drive('{0, 1, 1, 10, 'h50, 10});  tick;
    drive('{0, 10, 1, 11, 'h51, 15}); tick;
    drive('{0, 11, 1, 12, 'h52, 20});
    rd_en = 1'b1; rd_addr = 8'h30;
    tick;
    checks++;
    if (out_valid !== 1'b1 || Zout !== 16'd10 || rd_data !== 16'd5) begin
      errors++; $display("FAIL rstmid_pre: got v=%b z=%h rd=%h want v=1 z=000a rd=0005", out_valid, Zout, rd_data);
    end
    in_valid = 1'b0; rd_en = 1'b0;
    RST_N = 1'b0;
    #1;
    checks++;
    if (Zout !== 16'h0 || out_valid !== 1'b0 || ill_op !== 1'b0 || rd_data !== 16'h0) begin
      errors++; $display("FAIL rstmid_outputs: got z=%h v=%b ill=%b rd=%h want all 0", Zout, out_valid, ill_op, rd_data);
    end
    tick; tick;
    RST_N = 1'b1;
    rd_en = 1'b1; rd_addr = 8'h50;
    tick;
    checks++; if (rd_data !== 16'd5) begin errors++; $display("FAIL rstmid_no_store: got %h want 0005", rd_data); end
    rd_en = 1'b0;
    drive('{6, 10, 11, 13, 'hE0, 0});
    tick;
    in_valid = 1'b0;
    tick; tick;
    checks++;
    if (out_valid !== 1'b1 || Zout !== 16'h0) begin
      errors++; $display("FAIL rstmid_regbank: got v=%b z=%h want v=1 z=0000", out_valid, Zout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_build();
    test_forward();
    test_store_read();
    test_illegal();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
